// File: rtl/seq_ctrl_pkg.sv
// Shared types and default parameters for the serial pattern-detection run controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  localparam int PAT_W_DEF      = 4;
  localparam int CNT_W_DEF      = 8;
  localparam int TMO_CYCLES_DEF = 16;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping pattern matcher: history shift register, fill counter and registered match flag.
// match_next is the value match takes at the coming edge, so the controller can act on it in the same cycle.
module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match_next,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  shifted;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;

  // The fill counter saturates at PAT_W; a match needs a full window of bits from this run.
  always_comb begin
    shifted = {hist_q[PAT_W-2:0], bit_in};
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = shifted;
      if (fill_q != FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
      match_d = (fill_q >= FILL_W'(PAT_W - 1)) && (shifted == pattern);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match_next = match_d;
  assign match      = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller wrapping the pattern matcher into a start/done transaction with hit counting.
// Optional idle timeout is built only when SEQ_CTRL_TIMEOUT_EN is defined; otherwise timeout is tied low.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W      = PAT_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  output logic             timeout
);

  ctrl_state_e      state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] hit_inc;
  logic             bit_ready_q, bit_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             xfer;
  logic             shift_en;
  logic             core_clear;
  logic             match_next;
  logic             match_q;
  logic             final_hit;
  logic             tmo_fire;
  logic             start_run;

  assign xfer       = bit_valid && bit_ready_q;
  assign start_run  = (state_q == IDLE) && start;
  assign core_clear = start_run;
  // Abort wins over a same-cycle transfer, so that bit never reaches the history.
  assign shift_en   = xfer && !abort && (state_q == RUN);
  assign hit_inc    = hit_cnt_q + CNT_W'(1);
  assign final_hit  = match_next && (hit_inc == target_q);

  seq_match_core #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk        (clk),
    .rst        (rst),
    .clear      (core_clear),
    .shift_en   (shift_en),
    .bit_in     (bit_in),
    .pattern    (pattern_q),
    .match_next (match_next),
    .match      (match_q)
  );

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TMO_CYCLES + 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Counts idle RUN cycles; a transfer in the expiring cycle clears it instead of firing.
  always_comb begin
    timer_d  = timer_q;
    tmo_fire = 1'b0;
    if (state_q != RUN || xfer) begin
      timer_d = '0;
    end else begin
      tmo_fire = (timer_q == TMR_W'(TMO_CYCLES - 1));
      timer_d  = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic tmo_cfg_unused;
  assign tmo_cfg_unused = (TMO_CYCLES > 1);
  assign tmo_fire       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (target_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (final_hit || tmo_fire) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    bit_ready_d = (state_d == RUN);
    busy_d      = (state_d == RUN);
    done_d      = (state_d == DONE);
    timeout_d   = (state_q == RUN) && (state_d == DONE) && tmo_fire && !final_hit;
  end

  always_comb begin
    pattern_d = pattern_q;
    target_d  = target_q;
    hit_cnt_d = hit_cnt_q;
    if (start_run) begin
      pattern_d = pattern;
      target_d  = target_cnt;
      hit_cnt_d = '0;
    end else if (match_next) begin
      hit_cnt_d = hit_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q   <= '0;
      target_q    <= '0;
      hit_cnt_q   <= '0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      target_q    <= target_d;
      hit_cnt_q   <= hit_cnt_d;
      bit_ready_q <= bit_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign busy      = busy_q;
  assign hit       = match_q;
  assign hit_cnt   = hit_cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed runs plus random traffic against a bit-queue reference model.
// Honours SEQ_CTRL_TIMEOUT_EN so the model matches whichever build is compiled.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] target_cnt = '0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_ready, busy, hit, done, timeout;
  logic [CNT_W-1:0] hit_cnt;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .PAT_W      (PAT_W),
    .CNT_W      (CNT_W),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .target_cnt (target_cnt),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .busy       (busy),
    .hit        (hit),
    .hit_cnt    (hit_cnt),
    .done       (done),
    .timeout    (timeout)
  );

  typedef struct {
    int cyc;
    int busy;
    int ready;
    int cnt;
    int tmo;
  } status_t;

  typedef struct {
    int cyc;
    int hit;
    int done;
    int tmo;
    int cnt;
  } event_t;

  status_t stq[$];
  event_t  evq[$];
  int checks   = 0;
  int failures = 0;
  int scyc     = 0;

  // Reference model state: a run is a list of accepted bits plus a hit tally.
  bit   m_run = 1'b0;
  bit   m_fin = 1'b0;
  int   m_hits = 0;
  int   m_tgt = 0;
  int   m_idle = 0;
  int   m_pat = 0;
  int   m_bits[$];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Called once per cycle with the inputs in place; predicts outputs visible after the next edge.
  task automatic model_step();
    status_t s;
    event_t  e;
    int      h, d, t, v;
    h = 0; d = 0; t = 0; v = 0;
    if (!rst) begin
      m_run = 1'b0; m_fin = 1'b0; m_hits = 0; m_idle = 0;
      m_bits.delete();
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_pat = int'(pattern); m_tgt = int'(target_cnt); m_hits = 0; m_idle = 0;
        m_bits.delete();
        if (m_tgt == 0) begin d = 1; m_fin = 1'b1; end
        else m_run = 1'b1;
      end
    end else if (abort) begin
      m_run = 1'b0;
    end else if (bit_valid) begin
      m_bits.push_back(int'(bit_in));
      m_idle = 0;
      if (m_bits.size() >= PAT_W) begin
        for (int i = 0; i < PAT_W; i++) v = v * 2 + m_bits[m_bits.size() - PAT_W + i];
        if (v == m_pat) begin
          h = 1;
          m_hits++;
          if (m_hits == m_tgt) begin d = 1; m_run = 1'b0; m_fin = 1'b1; end
        end
      end
    end else begin
      m_idle++;
`ifdef SEQ_CTRL_TIMEOUT_EN
      if (m_idle == TMO) begin d = 1; t = 1; m_run = 1'b0; m_fin = 1'b1; end
`endif
    end
    s.cyc = scyc; s.busy = int'(m_run); s.ready = int'(m_run); s.cnt = m_hits; s.tmo = t;
    stq.push_back(s);
    if (h != 0 || d != 0) begin
      e.cyc = scyc; e.hit = h; e.done = d; e.tmo = t; e.cnt = m_hits;
      evq.push_back(e);
    end
    scyc++;
  endtask

  task automatic apply_stimulus(input logic rs, input logic st, input logic ab,
                                input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] tgt,
                                input logic bv, input logic bi);
    @(negedge clk);
    rst = rs; start = st; abort = ab; pattern = pat; target_cnt = tgt;
    bit_valid = bv; bit_in = bi;
    model_step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, pattern, target_cnt, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit toggle_valid);
    for (int i = n - 1; i >= 0; i--) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, pattern, target_cnt, 1'b1, bits[i]);
      if (toggle_valid) apply_stimulus(1'b1, 1'b0, 1'b0, pattern, target_cnt, 1'b0, 1'b0);
    end
  endtask

  task automatic begin_run(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] tgt);
    apply_stimulus(1'b1, 1'b1, 1'b0, pat, tgt, 1'b0, 1'b0);
  endtask

  task automatic reset_now();
    apply_stimulus(1'b0, 1'b0, 1'b0, pattern, target_cnt, 1'b0, 1'b0);
    #1;
    check_output("rst_bit_ready", int'(bit_ready), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_hit", int'(hit), 0);
    check_output("rst_hit_cnt", int'(hit_cnt), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_timeout", int'(timeout), 0);
  endtask

  // Monitor: per-cycle status from the queue, and hit/done pulses matched against the event queue.
  initial begin
    int      mcyc;
    status_t s;
    event_t  e;
    mcyc = 0;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (stq.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL status_underflow cycle=%0d actual=empty required=record", mcyc);
      end else begin
        s = stq.pop_front();
        check_output("busy", int'(busy), s.busy);
        check_output("bit_ready", int'(bit_ready), s.ready);
        check_output("hit_cnt", int'(hit_cnt), s.cnt);
        check_output("timeout_level", int'(timeout), s.tmo);
      end
      if (hit || done) begin
        if (evq.size() > 0 && evq[0].cyc == mcyc) begin
          e = evq.pop_front();
          check_output("ev_hit", int'(hit), e.hit);
          check_output("ev_done", int'(done), e.done);
          check_output("ev_timeout", int'(timeout), e.tmo);
          check_output("ev_hit_cnt", int'(hit_cnt), e.cnt);
        end else begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_event cycle=%0d actual hit=%0b done=%0b required=none",
                   mcyc, hit, done);
        end
      end else if (evq.size() > 0 && evq[0].cyc == mcyc) begin
        e = evq.pop_front();
        checks++; failures++;
        $display("[TB] FAIL missing_event cycle=%0d actual=none required hit=%0d done=%0d",
                 mcyc, e.hit, e.done);
      end
      mcyc++;
    end
  end

  initial begin
    logic [PAT_W-1:0] rpat;
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle_cycles(2);

    $display("[TB] pattern 1010 target 2, continuous stream");
    begin_run(4'b1010, 8'd2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1010, 8'd2, 1'b1, 1'b1);
    send_bits(16'b0_1010, 5, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1010, 8'd2, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b1010, 8'd2, 1'b1, 1'b0);
    idle_cycles(2);

    $display("[TB] pattern 1111 target 3, toggling valid");
    begin_run(4'b1111, 8'd3);
    send_bits(16'b11_1111, 6, 1'b1);
    idle_cycles(3);

    $display("[TB] target 0");
    begin_run(4'b0110, 8'd0);
    idle_cycles(3);

    $display("[TB] idle timeout, then late bit");
    begin_run(4'b0011, 8'd5);
    idle_cycles(20);
    apply_stimulus(1'b1, 1'b0, 1'b1, pattern, target_cnt, 1'b0, 1'b0);
    idle_cycles(1);
    begin_run(4'b0011, 8'd5);
    idle_cycles(14);
    send_bits(16'b1, 1, 1'b0);
    idle_cycles(15);
    apply_stimulus(1'b1, 1'b0, 1'b1, pattern, target_cnt, 1'b0, 1'b0);
    idle_cycles(18);

    $display("[TB] abort then restart");
    begin_run(4'b1010, 8'd2);
    send_bits(16'b101, 3, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'b1010, 8'd2, 1'b1, 1'b0);
    idle_cycles(2);
    begin_run(4'b1010, 8'd2);
    send_bits(16'b0, 1, 1'b0);
    send_bits(16'b1010, 4, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, pattern, target_cnt, 1'b0, 1'b0);
    idle_cycles(2);

    $display("[TB] reset mid-run after one hit");
    begin_run(4'b1010, 8'd3);
    send_bits(16'b1010, 4, 1'b0);
    reset_now();
    apply_stimulus(1'b0, 1'b0, 1'b0, pattern, target_cnt, 1'b0, 1'b0);
    idle_cycles(1);
    begin_run(4'b1010, 8'd2);
    send_bits(16'b10_1010, 6, 1'b0);
    idle_cycles(2);

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      if (n % 150 == 0) rpat = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
      apply_stimulus(($urandom_range(0, 299) != 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 39) == 0),
                     rpat,
                     CNT_W'($urandom_range(0, 4)),
                     ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)));
    end
    idle_cycles(20);

    @(posedge clk);
    #3;
    check_output("pending_events", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for the serial pattern-detection datapath. It accepts a programmable bit pattern and a target hit count, then pulls serial bits through a valid/ready handshake into an overlapping pattern matcher. It counts matches and ends the run on the target count, on an abort, or on an optional idle timeout. It sits between the serial-bit source and the status/interrupt logic, and turns a free-running detector into a start/done transaction.

## Interface
- PAT_W, 4: pattern length in bits (2..16).
- CNT_W, 8: width of target_cnt and hit_cnt.
- TMO_CYCLES, 16: idle-cycle limit for the timeout feature (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start pulse. Sampled only in IDLE.
- abort  in  1  ends a run with no done. Sampled only in RUN.
- pattern  in  PAT_W  pattern to match. pattern[PAT_W-1] is compared with the oldest bit. Latched at start.
- target_cnt  in  CNT_W  number of hits that ends the run. Latched at start.
- bit_valid  in  1  source has a bit.
- bit_in  in  1  serial data bit.
- bit_ready  out  1  controller accepts a bit. A bit transfers on a clock edge where bit_valid && bit_ready.
- busy  out  1  high in RUN.
- hit  out  1  one-cycle pulse per match.
- hit_cnt  out  CNT_W  matches counted in the current or last run.
- done  out  1  one-cycle pulse at the end of a run.
- timeout  out  1  qualifies done: the run ended by timeout.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE. All outputs are registered and reset to 0, including hit_cnt.
- IDLE:
  - bit_ready=0 and busy=0.
  - On start: latch pattern and target_cnt, clear hit_cnt, clear match history and idle timer.
  - Next state is RUN, or DONE if target_cnt==0.
- RUN:
  - bit_ready=1 and busy=1. start is ignored.
  - Each accepted bit shifts into the match history.
  - A match is declared when at least PAT_W bits have been accepted in this run and the last PAT_W bits equal pattern.
  - Matches overlap: the history is not cleared on a hit. For pattern 1010, the stream 1010 10 gives two hits.
  - On a match: hit pulses and hit_cnt increments.
  - If the incremented value equals target_cnt, next state is DONE. hit_cnt never exceeds target_cnt.
  - If abort is high: next state is IDLE, no done pulse, and hit_cnt keeps its value.
  - Abort has priority over a bit accepted in the same cycle; that bit is discarded.
- DONE:
  - done=1 for one cycle, bit_ready=0.
  - timeout=1 only if the run ended by timeout.
  - Next state is IDLE unconditionally. hit_cnt holds until the next start.
- Reset mid-run: return to IDLE immediately. Any partial history and count are lost.

## Timing
- Bit accepted at edge k completes a match: hit=1 and the new hit_cnt are visible in cycle k+1.
- Final hit: done=1 in the same cycle k+1 as its hit pulse. bit_ready falls in cycle k+1, so at most one bit per cycle is accepted and none after the final one.
- Start at edge s: bit_ready=1 from cycle s+1.
- target_cnt==0: done in cycle s+1, hit_cnt=0.
- Abort at edge a: busy=0 and bit_ready=0 from cycle a+1.
- Idle timer:
  - Cleared on entry to RUN and on every accepted bit.
  - Increments on every RUN cycle with no transfer.
  - The timer reaching TMO_CYCLES moves the state to DONE with timeout=1.
- Simultaneous events:
  - A transfer in the cycle the timer would expire wins: the timer clears and no timeout occurs.
  - A final hit and a timer expiry in the same cycle: the hit wins and timeout=0.

## Configuration
- SEQ_CTRL_TIMEOUT_EN defined: idle timer present, behaviour as above.
- SEQ_CTRL_TIMEOUT_EN undefined: no timer logic is built and timeout is tied to 0. A run ends only on the target count, abort or reset. The port list is unchanged.

## Structure
- Package seq_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default width constants PAT_W_DEF, CNT_W_DEF, TMO_CYCLES_DEF.
- Sub-module seq_match_core, inside the controller. It holds:
  - the PAT_W-bit history shift register and the fill counter;
  - a clear input, a shift-enable input, the bit input and the pattern input;
  - a registered match output.
- The controller keeps the FSM, hit_cnt, target latch and timer.

## Test plan
- Pattern 1010, target 2, stream 1,0,1,0,1,0 with bit_valid held high → hits after bits 4 and 6; done with the second hit; hit_cnt=2; bit_ready=0 afterwards.
- Pattern 1111, target 3, six 1s with bit_valid toggling every cycle → hits on bits 4, 5 and 6; no hit before 4 bits; done; hit_cnt=3.
- Target 0 → done one cycle after start; hit_cnt=0; bit_ready never high.
- Timeout enabled, TMO_CYCLES=16, bit_valid=0 after start → done=1 and timeout=1 sixteen cycles after entry to RUN. Same stimulus with a bit at cycle 15 → no timeout.
- Abort after bits 1,0,1 with pattern 1010 → IDLE with no done. Then restart and send bit 0 → no hit, because the history was cleared.
- Assert rst mid-RUN after one hit → all outputs 0 immediately. The next start runs normally.
